// File: rtl/lector_registros.sv
//------------------------------------------------------------------------------
// Module  : lector_registros
// Brief   : Scans a register-file read port from FIRST_REG to LAST_REG and
//           presents each word on a valid/ready handshake.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lector_registros #(
    parameter logic [3:0] FIRST_REG = 4'd0,
    parameter logic [3:0] LAST_REG  = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  addA,
    input  logic [31:0] doA,
    output logic [31:0] dato,
    output logic [3:0]  idx,
    output logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] dato_q,  dato_d;
    logic [3:0]  idx_q,   idx_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dato_d  = dato_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = FIRST_REG;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    dato_d  = doA;
                    idx_d   = cnt_q;
                    state_d = SEND;
                end
            end
            SEND: begin
                // abort wins over a simultaneous handshake
                if (abort) begin
                    state_d = IDLE;
                end else if (ready) begin
                    if (idx_q == LAST_REG) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = READ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= FIRST_REG;
            dato_q  <= 32'd0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dato_q  <= dato_d;
            idx_q   <= idx_d;
        end
    end

    assign addA  = cnt_q;
    assign dato  = dato_q;
    assign idx   = idx_q;
    assign valid = (state_q == SEND);
    assign busy  = (state_q == READ) || (state_q == SEND);
    assign done  = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_lector_registros.sv
//------------------------------------------------------------------------------
// Module  : tb_lector_registros
// Brief   : Scoreboard bench for lector_registros (default and single-register
//           configurations).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lector_registros;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [3:0]  addA, idx;
    logic [31:0] doA, dato;
    logic        valid, busy, done;

    logic        start2 = 1'b0;
    logic [3:0]  addA2, idx2;
    logic [31:0] doA2, dato2;
    logic        valid2, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    int n0;
    int d0;

    logic [35:0] sb_q[$];
    logic [35:0] sb2_q[$];
    int          xfer_edge[$];

    always #5 clk = ~clk;

    lector_registros dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .addA(addA), .doA(doA), .dato(dato), .idx(idx),
        .valid(valid), .ready(ready), .busy(busy), .done(done)
    );

    lector_registros #(.FIRST_REG(4'd14), .LAST_REG(4'd14)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .addA(addA2), .doA(doA2), .dato(dato2), .idx(idx2),
        .valid(valid2), .ready(1'b1), .busy(busy2), .done(done2)
    );

    assign doA  = 32'h1000_0000 + {28'd0, addA};
    assign doA2 = (addA2 == 4'd14) ? 32'hDEAD_BEEF : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are judged at the falling edge, ahead of the edge that takes them.
    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (done2) done2_cnt++;
        if (!rst && valid && ready && !abort) begin
            xfer_edge.push_back(cyc + 1);
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                logic [35:0] e;
                e = sb_q.pop_front();
                chk("idx", {28'd0, idx}, {28'd0, e[35:32]});
                chk("dato", dato, e[31:0]);
            end
        end
        if (!rst && valid2) begin
            if (sb2_q.size() == 0) begin
                chk("sb2_underflow", sb2_q.size(), 1);
            end else begin
                logic [35:0] e;
                e = sb2_q.pop_front();
                chk("idx2", {28'd0, idx2}, {28'd0, e[35:32]});
                chk("dato2", dato2, e[31:0]);
            end
        end
    end

    task automatic push_words(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [3:0] k;
            k = 4'(i);
            sb_q.push_back({k, 32'h1000_0000 + 32'(i)});
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (!done) chk("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_send(input logic [3:0] k);
        int n;
        n = 0;
        while (!(valid && idx == k) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (!(valid && idx == k)) chk("send_timeout", {28'd0, idx}, {28'd0, k});
    endtask

    task automatic pulse_start();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #1;
        n0 = cyc;
        start = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_addA", {28'd0, addA}, 32'd0);
        chk("rst_dato", dato, 32'd0);
        chk("rst_idx", {28'd0, idx}, 32'd0);
        chk("rst_flags", {29'd0, valid, busy, done}, 32'd0);
        chk("rst_addA2", {28'd0, addA2}, 32'd14);
        @(posedge clk); #2;
        rst = 1'b0;

        // Full scan with ready held high: latency and throughput
        xfer_edge.delete();
        d0 = done_cnt;
        push_words(0, 15);
        pulse_start();
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_valid", {31'd0, valid}, 32'd0);
        wait_done();
        chk("done_edge", 32'(cyc), 32'(n0 + 32));
        chk("n_xfer", 32'(xfer_edge.size()), 32'd16);
        if (xfer_edge.size() == 16) begin
            chk("first_edge", 32'(xfer_edge[0]), 32'(n0 + 2));
            chk("last_edge", 32'(xfer_edge[15]), 32'(n0 + 32));
        end
        chk("done_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("done_cnt1", 32'(done_cnt - d0), 32'd1);
        chk("sb_left1", 32'(sb_q.size()), 32'd0);

        // Back-pressure on word 3
        push_words(0, 15);
        pulse_start();
        wait_send(4'd3);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("hold_valid", {31'd0, valid}, 32'd1);
            chk("hold_idx", {28'd0, idx}, 32'd3);
            chk("hold_dato", dato, 32'h1000_0003);
        end
        ready = 1'b1;
        wait_done();
        @(posedge clk); #2;
        chk("sb_left2", 32'(sb_q.size()), 32'd0);

        // Abort during SEND of word 7 with ready high
        d0 = done_cnt;
        push_words(0, 6);
        pulse_start();
        wait_send(4'd7);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        #2;
        chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
        chk("sb_left3", 32'(sb_q.size()), 32'd0);
        push_words(0, 15);
        pulse_start();
        wait_done();
        @(posedge clk); #2;
        chk("sb_left4", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while reading word 9
        d0 = done_cnt;
        push_words(0, 8);
        pulse_start();
        begin
            int n;
            n = 0;
            while (!(busy && !valid && addA == 4'd9) && n < 200) begin
                @(posedge clk); #2;
                n++;
            end
            chk("read9_reached", {28'd0, addA}, 32'd9);
        end
        #1 rst = 1'b1;
        #1;
        chk("arst_flags", {29'd0, valid, busy, done}, 32'd0);
        chk("arst_dato", dato, 32'd0);
        chk("arst_idx", {28'd0, idx}, 32'd0);
        chk("arst_addA", {28'd0, addA}, 32'd0);
        @(posedge clk); #2;
        chk("arst_nodone", 32'(done_cnt - d0), 32'd0);
        chk("sb_left5", 32'(sb_q.size()), 32'd0);
        // start evaluated on the very first edge after release
        push_words(0, 15);
        rst = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_done();
        @(posedge clk); #2;
        chk("sb_left6", 32'(sb_q.size()), 32'd0);

        // start held 3 cycles, then again in DONE
        d0 = done_cnt;
        push_words(0, 15);
        @(posedge clk); #2;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("done_start_ign", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("still_idle", {31'd0, busy}, 32'd0);
        chk("one_scan", 32'(done_cnt - d0), 32'd1);
        chk("sb_left7", 32'(sb_q.size()), 32'd0);
        push_words(0, 15);
        pulse_start();
        wait_done();
        @(posedge clk); #2;
        chk("sb_left8", 32'(sb_q.size()), 32'd0);

        // Single-register configuration
        sb2_q.push_back({4'd14, 32'hDEAD_BEEF});
        @(posedge clk); #2;
        start2 = 1'b1;
        @(posedge clk); #2;
        start2 = 1'b0;
        begin
            int n;
            n = 0;
            while (!done2 && n < 20) begin
                @(posedge clk); #2;
                n++;
            end
            chk("done2_seen", {31'd0, done2}, 32'd1);
        end
        @(posedge clk); #2;
        chk("sb2_left", 32'(sb2_q.size()), 32'd0);
        chk("done2_cnt", 32'(done2_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
